countdown_sequencer: RTL and testbench
======================================

Name: countdown_sequencer

Overview:
- Controller that sequences a programmable WIDTH-bit down counter.
- Supports load, start, pause, resume, clear, one-shot and auto-reload modes, plus a tick prescaler.
- Emits a terminal-count pulse and a done status for downstream timing and control logic.
- Sits between software/control registers and any logic that needs "count N ticks, then signal".

Parameters:
WIDTH, 3, counter width in bits
PRESCALE_W, 4, width of prescale divider field

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_val  input  WIDTH  start value, latched on accepted start
prescale  input  PRESCALE_W  tick divider, latched on accepted start; tick every prescale+1 cycles
auto_reload  input  1  latched on accepted start; 1 = periodic, 0 = one-shot
start  input  1  load-and-run (IDLE/RUN/DONE) or resume (PAUSE)
stop  input  1  pause request
clear  input  1  synchronous abort to IDLE
count  output  WIDTH  current counter value
busy  output  1  high in RUN
paused  output  1  high in PAUSE
tc  output  1  one-cycle terminal-count pulse
done  output  1  high in DONE

Behaviour:
- Reset (async, active-high, any time including mid-count):
  - state=IDLE; count=0; prescaler=0; latched regs=0; tc=busy=paused=done=0.
  - Takes effect immediately, not at the next edge.
- States: IDLE, RUN, PAUSE, DONE. Outputs are registered. busy, paused and done decode the state.
- Control priority when several are high on one edge: clear > start > stop.
- clear (any state): IDLE, count=0, prescaler=0, tc=0.
- start in IDLE, DONE or RUN:
  - count=load_val, prescaler=0.
  - latch load_val, prescale and auto_reload.
  - state=RUN.
  - start in RUN restarts from the new load_val.
- start in PAUSE: resume to RUN. count, prescaler and latched regs are unchanged; no reload.
- stop in RUN: PAUSE. count and prescaler freeze. stop in any other state is ignored.
- Tick generation (RUN only):
  - tick when prescaler==latched prescale; prescaler then returns to 0, otherwise it increments.
  - latched prescale=0 gives a tick every cycle.
- On tick in RUN:
  - count>0: count=count-1.
  - count==0: tc=1 for exactly the next cycle.
    - auto_reload latched 1: count=latched load_val, stay RUN.
    - auto_reload latched 0: state=DONE, count stays 0.
- One-shot period: load_val+1 ticks from start to the tc edge. load_val=0 gives tc on the first tick.
- Auto-reload: tc period is (load_val+1)*(prescale+1) cycles, with no gap cycle.
- tc is a pulse; it is never held. It is 0 in every cycle with no terminal event.
- DONE holds until start (re-run) or clear (IDLE).
- Inputs changing while in RUN or PAUSE do not affect the current run; only the latched copies are used.
- stop and tick on the same edge: stop wins. No decrement happens and the prescaler freezes at its current value.
- Arithmetic: unsigned modulo-2^WIDTH. Decrement below 0 never occurs (the count==0 check precedes it).

Test Plan:
1. One-shot. WIDTH=3, prescale=0, auto_reload=0, load_val=5, start pulse at edge k.
   -> count 5,4,3,2,1,0 after edges k..k+5; tc=1 only after edge k+6; done=1 and count=0 from k+6; busy=0.
2. Auto-reload. load_val=2, auto_reload=1, prescale=0.
   -> count 2,1,0,2,1,0,...; tc pulses every 3 cycles; busy stays 1; done never asserts.
3. Prescale. prescale=2, load_val=1, one-shot.
   -> count changes only every 3rd cycle: 1 for 3 cycles, 0 for 3 cycles, then tc and DONE (6 cycles after start).
4. Pause/resume. load_val=7, stop at count=4, hold 5 cycles, then start.
   -> paused=1 and count frozen at 4; after resume count continues 3,2,1,0, then tc, with no reload to 7.
5. Priority. In RUN at count=3, assert clear+start together.
   -> IDLE, count=0. Then assert start+stop together with load_val=6 -> RUN, count=6, stop ignored.
6. Async reset. Assert reset mid-RUN between clock edges, at count=5.
   -> count=0, busy=0, tc=0 immediately without a clock edge. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/countdown_sequencer.sv
// Programmable down-counter sequencer with prescaler, pause/resume,
// one-shot and auto-reload modes, and a one-cycle terminal-count pulse.
module countdown_sequencer #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  auto_reload,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  paused,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic [WIDTH-1:0]        lat_load_q, lat_load_d;
    logic [PRESCALE_W-1:0]   lat_pre_q, lat_pre_d;
    logic                    lat_auto_q, lat_auto_d;
    logic                    tc_q, tc_d;
    logic                    tick;

    assign tick = (pre_q == lat_pre_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pre_q      <= '0;
            lat_load_q <= '0;
            lat_pre_q  <= '0;
            lat_auto_q <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            lat_load_q <= lat_load_d;
            lat_pre_q  <= lat_pre_d;
            lat_auto_q <= lat_auto_d;
            tc_q       <= tc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        lat_load_d = lat_load_q;
        lat_pre_d  = lat_pre_q;
        lat_auto_d = lat_auto_q;
        tc_d       = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (start) begin
            if (state_q == PAUSE) begin
                state_d = RUN;
            end else begin
                state_d    = RUN;
                count_d    = load_val;
                pre_d      = '0;
                lat_load_d = load_val;
                lat_pre_d  = prescale;
                lat_auto_d = auto_reload;
            end
        end else if (stop && state_q == RUN) begin
            // stop beats a coincident tick: everything freezes
            state_d = PAUSE;
        end else if (state_q == RUN) begin
            if (tick) begin
                pre_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
                    if (lat_auto_q) begin
                        count_d = lat_load_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end else begin
                pre_d = pre_q + PRESCALE_W'(1);
            end
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign busy   = (state_q == RUN);
    assign paused = (state_q == PAUSE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: tick-count model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_countdown_sequencer;

    localparam int WIDTH = 3;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] load_val = '0;
    logic [PW-1:0]    prescale = '0;
    logic             auto_reload = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy, paused, tc, done;

    int passed = 0;
    int total  = 0;

    countdown_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .load_val(load_val),
        .prescale(prescale), .auto_reload(auto_reload),
        .start(start), .stop(stop), .clear(clear),
        .count(count), .busy(busy), .paused(paused),
        .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 pause, 3 done. Count is derived from
    // the number of running cycles since the last (re)start.
    int m_mode = 0;
    int m_cyc  = 0;
    int m_L = 0, m_P = 0, m_A = 0;
    int m_tc = 0;

    always @(posedge clk or posedge reset) begin : mdl
        int nmode, ncyc, ntc, nl, np, na, t;
        nmode = m_mode; ncyc = m_cyc; ntc = 0;
        nl = m_L; np = m_P; na = m_A;
        if (reset) begin
            nmode = 0; ncyc = 0; nl = 0; np = 0; na = 0;
        end else if (clear) begin
            nmode = 0; ncyc = 0;
        end else if (start) begin
            if (m_mode == 2) nmode = 1;
            else begin
                nmode = 1; ncyc = 0;
                nl = int'(load_val); np = int'(prescale); na = int'(auto_reload);
            end
        end else if (stop && m_mode == 1) begin
            nmode = 2;
        end else if (m_mode == 1) begin
            ncyc = m_cyc + 1;
            if (ncyc % (np + 1) == 0) begin
                t = ncyc / (np + 1);
                if (t % (nl + 1) == 0) begin
                    ntc = 1;
                    if (na == 0) nmode = 3;
                end
            end
        end
        m_mode <= nmode; m_cyc <= ncyc; m_tc <= ntc;
        m_L <= nl; m_P <= np; m_A <= na;
    end

    function automatic int exp_count();
        int t;
        if (m_mode == 1 || m_mode == 2) begin
            t = m_cyc / (m_P + 1);
            return m_L - (t % (m_L + 1));
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        logic [WIDTH+3:0] e, a;
        #1;
        e = {WIDTH'(exp_count()), m_mode == 1, m_mode == 2, m_mode == 3, m_tc != 0};
        a = {count, busy, paused, done, tc};
        chk("model", int'(a), int'(e));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(input int lv, input int ps, input bit ar);
        load_val = WIDTH'(lv); prescale = PW'(ps); auto_reload = ar;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_count", count, 0);
        chk("rst_flags", {busy, paused, done, tc}, 0);
        reset = 1'b0;
        cyc();

        // one-shot
        go(5, 0, 0);
        chk("t1_c5", count, 5);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            chk("t1_down", count, i);
            chk("t1_notc", tc, 0);
        end
        cyc();
        chk("t1_tc", tc, 1);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        cyc();
        chk("t1_tc_pulse", tc, 0);
        chk("t1_done_hold", done, 1);
        chk("t1_count0", count, 0);

        // auto-reload
        go(2, 0, 1);
        chk("t2_c2", count, 2);
        cyc(2);
        chk("t2_c0", count, 0);
        cyc();
        chk("t2_reload", count, 2);
        chk("t2_tc", tc, 1);
        chk("t2_busy", busy, 1);
        cyc(3);
        chk("t2_tc2", tc, 1);
        chk("t2_nodone", done, 0);
        cyc(4);

        // prescale, restart from RUN
        go(1, 2, 0);
        chk("t3_c1a", count, 1);
        cyc(2);
        chk("t3_c1b", count, 1);
        cyc();
        chk("t3_c0a", count, 0);
        cyc(2);
        chk("t3_c0b", count, 0);
        chk("t3_notyet", done, 0);
        cyc();
        chk("t3_tc", tc, 1);
        chk("t3_done", done, 1);

        // pause / resume
        go(7, 0, 0);
        cyc(3);
        chk("t4_c4", count, 4);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4_paused", paused, 1);
        chk("t4_frz", count, 4);
        load_val = 3'd2;
        cyc(5);
        chk("t4_frz5", count, 4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_resume", count, 4);
        chk("t4_busy", busy, 1);
        cyc(4);
        chk("t4_c0", count, 0);
        cyc();
        chk("t4_tc", tc, 1);
        chk("t4_noreload", count, 0);

        // priority
        go(7, 0, 0);
        cyc(4);
        chk("t5_c3", count, 3);
        clear = 1'b1; start = 1'b1; load_val = 3'd6;
        cyc();
        clear = 1'b0; start = 1'b0;
        chk("t5_clr", count, 0);
        chk("t5_idle", {busy, paused, done}, 0);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t5_c6", count, 6);
        chk("t5_run", {busy, paused}, 2);

        // async reset mid-run
        go(7, 0, 0);
        cyc(2);
        chk("t6_c5", count, 5);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_cnt", count, 0);
        chk("t6_async_flg", {busy, tc}, 0);
        cyc();
        reset = 1'b0;
        cyc(3);
        chk("t6_stay_idle", {busy, paused, done}, 0);
        go(3, 0, 0);
        chk("t6_restart", count, 3);
        cyc(6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
